// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read-side burst controller feeding a 2-entry valid/ready output buffer.
// Optional feature macro FIFO_RD_STATS_EN adds stat_words/stat_bursts counters.
module fifo_rd_ctrl #(
   parameter int DATA_W     = 8,
   parameter int CNT_W      = 10,
   parameter int START_MODE = 0,
   parameter int START_LVL  = 512,
   parameter int MAX_BURST  = 0,
   parameter int SYNC_STG   = 2
) (
   input  logic              rd_clk,
   input  logic              rst_n,
   input  logic              rd_rst_busy,
   input  logic              full,
   input  logic              empty,
   input  logic              almost_empty,
   input  logic [CNT_W-1:0]  rd_data_count,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              burst_done,
   output logic              busy
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [31:0]       stat_words,
   output logic [15:0]       stat_bursts
`endif
);
   localparam int IW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
   localparam logic [IW-1:0] CAP = IW'(MAX_BURST);
   localparam logic [CNT_W:0] LVL = (CNT_W + 1)'(START_LVL);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state;
   logic [SYNC_STG-1:0] full_sync;
   logic full_s, start, inflight, pop, cap_hit;
   logic [1:0] buf_cnt;
   logic [2:0] occ;
   logic [DATA_W-1:0] tail;
   logic [IW-1:0] issued;
   assign full_s = full_sync[SYNC_STG-1];
   assign start = START_MODE == 0 ? full_s : {1'b0, rd_data_count} >= LVL;
   assign pop = out_valid & out_ready;
   assign cap_hit = MAX_BURST != 0 && issued == CAP;
   assign out_valid = buf_cnt != 2'd0;
   // Occupancy after this edge; crediting the pop keeps a full-rate stream
   assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
   assign fifo_rd_en = state == READ && !empty && !rd_rst_busy && occ < 3'd2 && !cap_hit;
   // Bring the write-domain full flag into rd_clk
   always_ff @(posedge rd_clk or negedge rst_n)
      if (!rst_n) full_sync <= '0;
      else full_sync <= {full_sync[SYNC_STG-2:0], full};
   // Burst sequencing with registered busy and burst_done
   always_ff @(posedge rd_clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         case (state)
            IDLE:
               if (!rd_rst_busy && start) begin
                  state <= READ;
                  busy <= 1'b1;
               end
            READ:
               if (rd_rst_busy || almost_empty || empty || cap_hit) state <= DRAIN;
            DRAIN:
               if (!inflight && buf_cnt == 2'd0) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  burst_done <= 1'b1;
               end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   // Track the read landing next cycle and the words issued this burst
   always_ff @(posedge rd_clk or negedge rst_n)
      if (!rst_n) begin
         inflight <= 1'b0;
         issued <= '0;
      end else begin
         inflight <= fifo_rd_en;
         issued <= state == IDLE ? '0 : issued + IW'(fifo_rd_en);
      end
   // Two-entry output buffer: out_data is the head, tail holds the second word
   always_ff @(posedge rd_clk or negedge rst_n)
      if (!rst_n) begin
         buf_cnt <= 2'd0;
         out_data <= '0;
         tail <= '0;
      end else begin
         buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
         if (inflight && (buf_cnt == 2'd0 || (buf_cnt == 2'd1 && pop))) out_data <= fifo_rd_data;
         else if (pop && buf_cnt == 2'd2) out_data <= tail;
         if (inflight && ((buf_cnt == 2'd1 && !pop) || buf_cnt == 2'd2)) tail <= fifo_rd_data;
      end
`ifdef FIFO_RD_STATS_EN
   // Handshake and burst counters, wrapping naturally
   always_ff @(posedge rd_clk or negedge rst_n)
      if (!rst_n) begin
         stat_words <= '0;
         stat_bursts <= '0;
      end else begin
         stat_words <= stat_words + 32'(pop);
         stat_bursts <= stat_bursts + 16'(burst_done);
      end
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: two controller instances (full-start/unlimited and level-start/8-word cap) against a FIFO model and an in-order scoreboard.
module tb_fifo_rd_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic rrb[2], full[2], empty[2], ae[2], rd_en[2], ovalid[2], oready[2], bdone[2], busy[2];
   logic [9:0] cnt[2];
   logic [7:0] rdata[2], odata[2];
`ifdef FIFO_RD_STATS_EN
   logic [31:0] sw[2];
   logic [15:0] sbu[2];
`endif
   logic [7:0] mem[2][1024];
   int wp[2], rp[2], hp[2], pend[2];
   int nrd[2], nhs[2], nbd[2], brd[2], lastb[2];
   int first_rd[2], first_hs[2], last_hs[2];
   logic pv[2], rd_now[2];
   logic [7:0] pd[2];
   int cyc, errs, checks;
   int n, c_prev, h0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      fifo_rd_ctrl #(.START_MODE(g), .START_LVL(g == 0 ? 512 : 16), .MAX_BURST(g * 8)) dut (
         .rd_clk(clk), .rst_n(rst_n), .rd_rst_busy(rrb[g]), .full(full[g]), .empty(empty[g]),
         .almost_empty(ae[g]), .rd_data_count(cnt[g]), .fifo_rd_data(rdata[g]), .fifo_rd_en(rd_en[g]),
         .out_data(odata[g]), .out_valid(ovalid[g]), .out_ready(oready[g]), .burst_done(bdone[g]),
`ifdef FIFO_RD_STATS_EN
         .stat_words(sw[g]), .stat_bursts(sbu[g]),
`endif
         .busy(busy[g])
      );
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic void flags();
      int c;
      for (int i = 0; i < 2; i++) begin
         c = wp[i] - rp[i];
         cnt[i] = 10'(c);
         empty[i] = c == 0;
         ae[i] = c <= 1;
         full[i] = c >= 512;
      end
   endfunction
   task automatic clr(input int i);
      nrd[i] = 0; nhs[i] = 0; nbd[i] = 0;
      first_rd[i] = -1; first_hs[i] = -1; last_hs[i] = -1;
   endtask
   task automatic step();
      #1;
      for (int i = 0; i < 2; i++) begin
         if (rd_en[i]) chk("rd_while_empty", 32'(empty[i]), 0);
         if (rrb[i]) chk("rd_during_rrb", 32'(rd_en[i]), 0);
         if (pv[i]) begin
            chk("stall_valid", 32'(ovalid[i]), 1);
            chk("stall_data", 32'(odata[i]), 32'(pd[i]));
         end
         chk("outstanding", 32'(rp[i] - hp[i] <= 2), 1);
         if (ovalid[i] && oready[i]) begin
            chk("data", 32'(odata[i]), 32'(mem[i][hp[i] & 1023]));
            hp[i]++;
            nhs[i]++;
            if (first_hs[i] < 0) first_hs[i] = cyc;
            last_hs[i] = cyc;
         end
         if (rd_en[i]) begin
            nrd[i]++;
            brd[i]++;
            if (first_rd[i] < 0) first_rd[i] = cyc;
         end
         if (bdone[i]) begin
            nbd[i]++;
            lastb[i] = brd[i];
            brd[i] = 0;
         end
         pv[i] = ovalid[i] & ~oready[i];
         pd[i] = odata[i];
         rd_now[i] = rd_en[i];
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rd_now[i]) begin
            rdata[i] = mem[i][rp[i] & 1023];
            rp[i]++;
         end else rdata[i] = 8'($urandom);
         if (pend[i] > 0 && wp[i] - rp[i] < 512) begin
            mem[i][wp[i] & 1023] = 8'($urandom);
            wp[i]++;
            pend[i]--;
         end
      end
      flags();
      @(negedge clk);
   endtask
   task automatic wait_busy(input int i, input int lim, output int k);
      k = 0;
      while (busy[i] !== 1'b1 && k < lim) begin
         step();
         k++;
      end
      chk("start_timeout", 32'(busy[i]), 1);
   endtask
   task automatic run_done(input string tag, input int i, input int lim, input bit rnd);
      int b0, k;
      b0 = nbd[i];
      k = 0;
      while (nbd[i] == b0 && k < lim) begin
         if (rnd) oready[i] = 1'($urandom_range(0, 1));
         step();
         k++;
      end
      oready[i] = 1'b1;
      chk(tag, nbd[i] - b0, 1);
   endtask
   task automatic fill_full(input int i);
      clr(i);
      pend[i] = 512 - (wp[i] - rp[i]);
   endtask
   task automatic chk_zero(input string tag, input int i);
      chk({tag, "_rd_en"}, 32'(rd_en[i]), 0);
      chk({tag, "_valid"}, 32'(ovalid[i]), 0);
      chk({tag, "_data"}, 32'(odata[i]), 0);
      chk({tag, "_bdone"}, 32'(bdone[i]), 0);
      chk({tag, "_busy"}, 32'(busy[i]), 0);
`ifdef FIFO_RD_STATS_EN
      chk({tag, "_stat_words"}, sw[i], 0);
      chk({tag, "_stat_bursts"}, 32'(sbu[i]), 0);
`endif
   endtask
   initial begin
      errs = 0; checks = 0; cyc = 0; rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rrb[i] = 0; oready[i] = 0; wp[i] = 0; rp[i] = 0; hp[i] = 0; pend[i] = 0;
         brd[i] = 0; lastb[i] = 0; pv[i] = 0; rdata[i] = 0;
         clr(i);
      end
      flags();
      repeat (3) @(negedge clk);
      #1;
      chk_zero("reset0", 0);
      chk_zero("reset1", 1);
      rst_n = 1'b1;
      step();
      step();
      // T2: level start at 16 words with an 8-word cap
      oready[1] = 1; clr(1); pend[1] = 20; n = 0; c_prev = 0;
      while (busy[1] !== 1'b1 && n < 40) begin
         c_prev = int'(cnt[1]);
         step();
         n++;
      end
      chk("t2_started", 32'(busy[1]), 1);
      chk("t2_start_level", c_prev, 16);
      run_done("t2_done", 1, 60, 0);
      chk("t2_reads", nrd[1], 8);
      chk("t2_handshakes", nhs[1], 8);
      chk("t2_burst_len", lastb[1], 8);
      repeat (20) step();
      chk("t2_no_restart", 32'(busy[1]), 0);
      chk("t2_reads_after", nrd[1], 8);
      // T3: 100 words held, capped bursts of 8 with random consumer stalls
      for (int k = 0; k < 88; k++) begin
         mem[1][wp[1] & 1023] = 8'($urandom);
         wp[1]++;
      end
      flags();
      clr(1);
      run_done("t3_done1", 1, 200, 1);
      chk("t3_burst1_len", lastb[1], 8);
      run_done("t3_done2", 1, 200, 1);
      chk("t3_burst2_len", lastb[1], 8);
      chk("t3_reads", nrd[1], 16);
      chk("t3_handshakes", nhs[1], 16);
      // T1: full-start drain of 512 words at full rate
      oready[0] = 1;
      fill_full(0);
      n = 0;
      while (full[0] !== 1'b1 && n < 600) begin
         step();
         n++;
      end
      chk("t1_idle_before_sync", 32'(busy[0]), 0);
      wait_busy(0, 10, n);
      chk("t1_start_latency", n, 3);
      run_done("t1_done", 0, 700, 0);
      chk("t1_reads", nrd[0], 512);
      chk("t1_handshakes", nhs[0], 512);
      chk("t1_latency", first_hs[0] - first_rd[0], 2);
      chk("t1_back_to_back", last_hs[0] - first_hs[0], 511);
      repeat (5) step();
      chk("t1_single_pulse", nbd[0], 1);
      chk("t1_idle", 32'(busy[0]), 0);
      // T4: consumer stall of 10 cycles mid-burst
      fill_full(0);
      wait_busy(0, 600, n);
      repeat (40) step();
      oready[0] = 0;
      h0 = nhs[0];
      repeat (10) step();
      chk("t4_no_handshake", nhs[0] - h0, 0);
      chk("t4_two_held", rp[0] - hp[0], 2);
      oready[0] = 1;
      h0 = nhs[0];
      repeat (20) step();
      chk("t4_resume_rate", nhs[0] - h0, 20);
      run_done("t4_done", 0, 700, 0);
      chk("t4_reads", nrd[0], 512);
      chk("t4_no_loss", hp[0] - rp[0], 0);
      // Random consumer readiness over a whole burst
      fill_full(0);
      wait_busy(0, 600, n);
      run_done("rand_done", 0, 3000, 1);
      chk("rand_reads", nrd[0], 512);
      chk("rand_no_loss", hp[0] - rp[0], 0);
      // T5: FIFO read reset busy mid-burst
      fill_full(0);
      wait_busy(0, 600, n);
      repeat (30) step();
      rrb[0] = 1;
      step();
      run_done("t5_done", 0, 50, 0);
      chk("t5_drained", rp[0] - hp[0], 0);
      chk("t5_partial", 32'(nrd[0] < 512), 1);
      rrb[0] = 0;
      repeat (5) step();
      chk("t5_no_restart", 32'(busy[0]), 0);
      // T6: asynchronous reset mid-burst
      fill_full(0);
      wait_busy(0, 600, n);
      repeat (20) step();
      chk("t6_mid_burst", 32'(ovalid[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("t6_async", 0);
      for (int i = 0; i < 2; i++) begin
         hp[i] = rp[i];
         brd[i] = 0;
         pv[i] = 0;
      end
      h0 = nbd[0];
      step();
      step();
      chk("t6_no_pulse", nbd[0] - h0, 0);
      chk_zero("t6_held", 0);
      rst_n = 1'b1;
      step();
      fill_full(0);
      wait_busy(0, 100, n);
      run_done("t6_done", 0, 700, 0);
      chk("t6_reads", nrd[0], 512);
      chk("t6_no_loss", hp[0] - rp[0], 0);
      chk("t6_one_pulse", nbd[0], 1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
